// File: rtl/mod_counter_n.sv
// Parametrised synchronous modulo-MODULUS up/down counter with load, enable,
// cascade terminal count and registered wrap pulse. Optional prescaler: MOD_COUNTER_PRESCALE_EN.
module mod_counter_n #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
`ifdef MOD_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("mod_counter_n: WIDTH must be in 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("mod_counter_n: MODULUS must be in 2..2**WIDTH");
    end

    logic             at_last;
    logic             at_zero;
    logic             step;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    assign at_last = (q == LAST);
    assign at_zero = (q == '0);

`ifdef MOD_COUNTER_PRESCALE_EN
    if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
        $error("mod_counter_n: PRESCALE must be in 2..256");
    end

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;
    logic          pre_last;

    assign pre_last = (pre_cnt == PRE_LAST);

    // Prescaler restarts on load so a freshly loaded value dwells a full period.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            pre_cnt <= '0;
        end else if (ld) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= pre_last ? '0 : pre_cnt + PW'(1);
        end
    end

    assign step = en & pre_last;
`else
    assign step = en;
`endif

    assign tc = step & ((up & at_last) | (~up & at_zero));

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (ld) begin
            q_next = (d > LAST) ? LAST : d;
        end else if (step) begin
            if (up) begin
                if (at_last) begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    q_next    = LAST;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_mod_counter_n.sv
// Directed self-checking bench for mod_counter_n (default build, no prescaler).
module tb_mod_counter_n;

    logic clk = 1'b0;
    logic rs  = 1'b1;

    logic       en16 = 1'b0, up16 = 1'b1, ld16 = 1'b0;
    logic [3:0] d16  = 4'd0;
    logic [3:0] q16;
    logic       tc16, wrap16;

    logic       en10 = 1'b0, up10 = 1'b1, ld10 = 1'b0;
    logic [3:0] d10  = 4'd0;
    logic [3:0] q10;
    logic       tc10, wrap10;

    logic       enc = 1'b0;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, wrap_lo, wrap_hi;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mod_counter_n #(.WIDTH(4), .MODULUS(16)) u_hex (
        .clk(clk), .rs(rs), .en(en16), .up(up16), .ld(ld16), .d(d16),
        .q(q16), .tc(tc16), .wrap(wrap16)
    );

    mod_counter_n #(.WIDTH(4), .MODULUS(10)) u_dec (
        .clk(clk), .rs(rs), .en(en10), .up(up10), .ld(ld10), .d(d10),
        .q(q10), .tc(tc10), .wrap(wrap10)
    );

    mod_counter_n #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .rs(rs), .en(enc), .up(1'b1), .ld(1'b0), .d(4'd0),
        .q(q_lo), .tc(tc_lo), .wrap(wrap_lo)
    );

    mod_counter_n #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .rs(rs), .en(tc_lo), .up(1'b1), .ld(1'b0), .d(4'd0),
        .q(q_hi), .tc(tc_hi), .wrap(wrap_hi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] dec_q [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic [3:0] prev;
    int         hi_wraps;

    initial begin
        // Async clear before any clock edge
        #2 rs = 1'b0;
        #1;
        chk("rst_q16", q16, 0);
        chk("rst_wrap16", wrap16, 0);
        chk("rst_q10", q10, 0);
        chk("rst_casc", {q_hi, q_lo}, 0);

        en16 = 1'b1;
        tick;
        tick;
        chk("hold_in_rst_q16", q16, 0);
        chk("hold_in_rst_tc16", tc16, 0);
        @(negedge clk) rs = 1'b1;

        // Full hex up-count 1..15,0
        for (int i = 1; i <= 16; i++) begin
            tick;
            chk("hex_q", q16, i % 16);
            chk("hex_wrap", wrap16, (i == 16) ? 1 : 0);
            chk("hex_tc", tc16, (i == 15) ? 1 : 0);
        end
        en16 = 1'b0;

        // Decade up-count
        en10 = 1'b1;
        up10 = 1'b1;
        prev = 4'd0;
        for (int i = 0; i < 12; i++) begin
            chk("dec_tc", tc10, (prev == 4'd9) ? 1 : 0);
            tick;
            chk("dec_q", q10, dec_q[i]);
            chk("dec_wrap", wrap10, (prev == 4'd9) ? 1 : 0);
            prev = dec_q[i];
        end

        // Down-count through zero
        ld10 = 1'b1;
        d10  = 4'd2;
        tick;
        chk("dn_load_q", q10, 2);
        ld10 = 1'b0;
        up10 = 1'b0;
        tick;
        chk("dn_q1", q10, 1);
        tick;
        chk("dn_q0", q10, 0);
        chk("dn_tc_at0", tc10, 1);
        up10 = 1'b1;
        #1;
        chk("dir_flip_tc", tc10, 0);
        up10 = 1'b0;
        tick;
        chk("dn_q9", q10, 9);
        chk("dn_wrap9", wrap10, 1);
        tick;
        chk("dn_q8", q10, 8);
        chk("dn_wrap8", wrap10, 0);

        // Load priority and clamp
        up10 = 1'b1;
        tick;
        chk("pre_ld_q9", q10, 9);
        chk("pre_ld_wrap", wrap10, 0);
        ld10 = 1'b1;
        d10  = 4'd13;
        #1;
        chk("ld_tc_prestate", tc10, 1);
        tick;
        chk("ld_clamp_q", q10, 9);
        chk("ld_clamp_wrap", wrap10, 0);
        d10 = 4'd4;
        tick;
        chk("ld4_q", q10, 4);
        d10 = 4'd10;
        tick;
        chk("ld10_clamp_q", q10, 9);
        ld10 = 1'b0;
        en10 = 1'b0;
        #1;
        chk("hold_tc", tc10, 0);
        tick;
        chk("hold_q", q10, 9);
        chk("hold_wrap", wrap10, 0);

        // Two-digit cascade 00..99 -> 00
        enc = 1'b1;
        hi_wraps = 0;
        for (int i = 1; i <= 100; i++) begin
            tick;
            chk("casc_count", q_hi * 10 + q_lo, i % 100);
            chk("casc_wrap_lo", wrap_lo, (i % 10 == 0) ? 1 : 0);
            chk("casc_wrap_hi", wrap_hi, (i == 100) ? 1 : 0);
            if (wrap_hi) hi_wraps++;
        end
        enc = 1'b0;
        chk("casc_hi_wrap_count", hi_wraps, 1);

        // Mid-count async reset
        en16 = 1'b1;
        repeat (7) tick;
        chk("mid_q7", q16, 7);
        #2 rs = 1'b0;
        #1;
        chk("mid_rst_q", q16, 0);
        chk("mid_rst_wrap", wrap16, 0);
        @(negedge clk) rs = 1'b1;
        tick;
        chk("restart_q1", q16, 1);
        tick;
        chk("restart_q2", q16, 2);

        // Reset clears a pending wrap pulse
        ld16 = 1'b1;
        d16  = 4'd15;
        tick;
        chk("ld15_q", q16, 15);
        ld16 = 1'b0;
        tick;
        chk("wrap_pend_q", q16, 0);
        chk("wrap_pend_wrap", wrap16, 1);
        #2 rs = 1'b0;
        #1;
        chk("wrap_clr_wrap", wrap16, 0);
        chk("wrap_clr_q", q16, 0);
        @(negedge clk) rs = 1'b1;
        tick;
        chk("post_clr_q", q16, 1);
        chk("post_clr_wrap", wrap16, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
